// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier built on radix-4 Booth recoding.
// Operands are reduced to magnitudes by two abs instances. One Booth digit
// is retired per cycle, and the result sign is applied in a final cycle.

// Two's-complement magnitude; the result is unsigned so the most negative
// input maps to 2^(W-1) without overflow.
module booth_abs #(
   parameter int W = 8
) (
   input  logic signed [W-1:0] din,
   output logic        [W-1:0] mag
);

   assign mag = din[W-1] ? (~din + 1'b1) : din;

endmodule

module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH-1:0]     a,
   input  logic signed [WIDTH-1:0]     b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [2*WIDTH-1:0]   product,
   output logic                        busy
);

   localparam int ITER = (WIDTH + 2) / 2;
   localparam int MW   = WIDTH + 2;        // zero-extended magnitude width
   localparam int AW   = 2 * WIDTH + 2;    // accumulator width
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [WIDTH-1:0]       abs_a;
   logic [WIDTH-1:0]       abs_b;
   logic [MW-1:0]          mag_a;
   logic [MW:0]            mul_sr;     // multiplier magnitude with appended 0 LSB
   logic signed [AW-1:0]   acc;
   logic                   neg;
   logic [CW-1:0]          cnt;

   logic                   accept;
   logic                   zero_op;
   logic                   last_digit;

   // Booth partial product for one 3-bit window of the multiplier.
   function automatic logic signed [AW-1:0] booth_pp(input logic [2:0]    bits,
                                                      input logic [MW-1:0] m);
      logic signed [AW-1:0] m_ext;
      m_ext = signed'({{(AW-MW){1'b0}}, m});
      case (bits)
         3'b001, 3'b010: booth_pp = m_ext;
         3'b011:         booth_pp = m_ext <<< 1;
         3'b100:         booth_pp = -(m_ext <<< 1);
         3'b101, 3'b110: booth_pp = -m_ext;
         default:        booth_pp = '0;
      endcase
   endfunction

   // Truncate the accumulated magnitude to the product width and apply the sign.
   function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic                 n,
                                                            input logic signed [AW-1:0] v);
      logic signed [2*WIDTH-1:0] t;
      t = v[2*WIDTH-1:0];
      apply_sign = n ? -t : t;
   endfunction

   booth_abs #(.W(WIDTH)) u_abs_a (
      .din (a),
      .mag (abs_a)
   );

   booth_abs #(.W(WIDTH)) u_abs_b (
      .din (b),
      .mag (abs_b)
   );

   assign accept     = (state == IDLE) && in_valid;
   assign zero_op    = (abs_a == '0) || (abs_b == '0);
   assign last_digit = (cnt == CW'(ITER - 1));

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign busy       = (state == CALC) || (state == SIGN);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: zero operands skip straight to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid)   state_nxt = zero_op ? DONE : CALC;
         CALC: if (last_digit) state_nxt = SIGN;
         SIGN:                 state_nxt = DONE;
         DONE: if (out_ready)  state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // Operand capture, per-digit accumulation and sign application.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a   <= '0;
         mul_sr  <= '0;
         neg     <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mag_a  <= {2'b00, abs_a};
                  mul_sr <= {2'b00, abs_b, 1'b0};
                  neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                  acc    <= '0;
                  cnt    <= '0;
                  if (zero_op) begin
                     product <= '0;
                  end
               end
            end
            CALC: begin
               acc    <= acc + (booth_pp(mul_sr[2:0], mag_a) <<< {cnt, 1'b0});
               mul_sr <= mul_sr >> 2;
               cnt    <= cnt + 1'b1;
            end
            SIGN: begin
               product <= apply_sign(neg, acc);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
